// File: rtl/uart_config_requester_pkg.sv
// Shared UART configuration types and helpers, plus the requester FSM encoding
// and the configuration-sequence constants.
package uart_config_requester_pkg;

    typedef enum logic [1:0] {
        DW_5BIT = 2'b00,
        DW_6BIT = 2'b01,
        DW_7BIT = 2'b10,
        DW_8BIT = 2'b11
    } data_width_e;

    typedef enum logic [1:0] {
        EVEN      = 2'b00,
        ODD       = 2'b01,
        DISABLED1 = 2'b10,
        DISABLED2 = 2'b11
    } parity_mode_e;

    typedef enum logic [1:0] {
        SB_1BIT   = 2'b00,
        SB_2BIT   = 2'b01,
        RESERVED1 = 2'b10,
        RESERVED2 = 2'b11
    } stop_bits_e;

    typedef struct packed {
        data_width_e  data_width;
        parity_mode_e parity_mode;
        stop_bits_e   stop_bits;
    } uart_config_s;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_SYN = 3'd1,
        SEND_DW  = 3'd2,
        SEND_PM  = 3'd3,
        SEND_SB  = 3'd4,
        SEND_END = 3'd5
    } requester_state_e;

    localparam uart_config_s STD_CONFIGURATION = '{DW_8BIT, EVEN, SB_1BIT};

    localparam logic [7:0]  SYN                  = 8'h16;
    localparam int unsigned SYN_NUMBER           = 3;
    localparam int unsigned CFG_SEQ_LENGTH       = SYN_NUMBER + 4;

    localparam logic [1:0]  END_CONFIGURATION_ID = 2'b00;
    localparam logic [1:0]  DATA_WIDTH_ID        = 2'b01;
    localparam logic [1:0]  PARITY_MODE_ID       = 2'b10;
    localparam logic [1:0]  STOP_BITS_ID         = 2'b11;

    function automatic logic [7:0] assemble_packet(input logic [1:0] option,
                                                   input logic [1:0] id);
        return {4'b0000, option, id};
    endfunction

    function automatic logic is_legal_config(input uart_config_s cfg);
        return !(cfg.stop_bits == RESERVED1 || cfg.stop_bits == RESERVED2);
    endfunction

endpackage

// File: rtl/uart_config_requester.sv
// Initiator of the UART run-time configuration protocol: SYN preamble, three
// option packets and an end packet, then the new configuration is applied locally.
module uart_config_requester
    import uart_config_requester_pkg::*;
#(
    parameter int unsigned SYN_COUNT = SYN_NUMBER
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] req_config_i,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [7:0] tx_data_o,
    input  logic       tx_done_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [5:0] cur_config_o
);

    typedef enum logic {
        PH_OFFER = 1'b0,
        PH_WAIT  = 1'b1
    } phase_e;

    localparam logic [1:0] LAST_SYN = 2'(SYN_COUNT - 1);

    requester_state_e state;
    phase_e           phase;
    logic [1:0]       syn_cnt;
    uart_config_s     latched;
    uart_config_s     cur_config;
    uart_config_s     req_config;

    assign req_config   = uart_config_s'(req_config_i);
    assign cur_config_o = cur_config;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            phase      <= PH_OFFER;
            syn_cnt    <= '0;
            latched    <= STD_CONFIGURATION;
            cur_config <= STD_CONFIGURATION;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        latched <= req_config;
                        if (is_legal_config(req_config)) begin
                            state      <= SEND_SYN;
                            phase      <= PH_OFFER;
                            syn_cnt    <= '0;
                            busy_o     <= 1'b1;
                            tx_valid_o <= 1'b1;
                            tx_data_o  <= SYN;
                        end else begin
                            error_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    // tx_done_i only counts in WAIT, so a done coincident with acceptance is dropped
                    if (phase == PH_OFFER) begin
                        if (tx_ready_i) begin
                            tx_valid_o <= 1'b0;
                            phase      <= PH_WAIT;
                        end
                    end else if (tx_done_i) begin
                        phase      <= PH_OFFER;
                        tx_valid_o <= 1'b1;
                        case (state)
                            SEND_SYN: begin
                                syn_cnt <= syn_cnt + 2'd1;
                                if (syn_cnt == LAST_SYN) begin
                                    state     <= SEND_DW;
                                    tx_data_o <= assemble_packet(latched.data_width, DATA_WIDTH_ID);
                                end else begin
                                    tx_data_o <= SYN;
                                end
                            end
                            SEND_DW: begin
                                state     <= SEND_PM;
                                tx_data_o <= assemble_packet(latched.parity_mode, PARITY_MODE_ID);
                            end
                            SEND_PM: begin
                                state     <= SEND_SB;
                                tx_data_o <= assemble_packet(latched.stop_bits, STOP_BITS_ID);
                            end
                            SEND_SB: begin
                                state     <= SEND_END;
                                tx_data_o <= assemble_packet(2'b00, END_CONFIGURATION_ID);
                            end
                            default: begin
                                state      <= IDLE;
                                tx_valid_o <= 1'b0;
                                busy_o     <= 1'b0;
                                done_o     <= 1'b1;
                                cur_config <= latched;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_config_requester.sv
// Directed bench for uart_config_requester with a simple transmitter model
// that answers each accepted byte with tx_done_i ten cycles later.
module tb_uart_config_requester;

    logic       clk_i;
    logic       rst_i;
    logic       start_i;
    logic [5:0] req_config_i;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic [7:0] tx_data_o;
    logic       tx_done_i;
    logic       busy_o;
    logic       done_o;
    logic       error_o;
    logic [5:0] cur_config_o;

    uart_config_requester #(.SYN_COUNT(3)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .req_config_i (req_config_i),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .tx_data_o    (tx_data_o),
        .tx_done_i    (tx_done_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .cur_config_o (cur_config_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks;
    int passes;

    logic [7:0] cap [16];
    logic [7:0] exp_b [7];
    int         cap_n;
    bit         stable_ok;
    bit         cfg_early;
    bit         done_seen;
    logic [5:0] cfg_at_done;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one full sequence against the transmitter model, capturing accepted bytes.
    task automatic run_seq(input logic [5:0] cfg, input int ready_low,
                           input bit second_start, input bit spurious);
        int pend;
        int low_left;
        int cyc;
        logic [5:0] cfg_before;
        logic prev_v;
        logic [7:0] prev_d;
        cap_n = 0; stable_ok = 1; cfg_early = 0; done_seen = 0; cfg_at_done = 'x;
        cfg_before = cur_config_o;
        req_config_i = cfg;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        pend = 0; low_left = ready_low; cyc = 0; prev_v = 1'b0; prev_d = '0;
        while (cyc < 3000) begin
            if (done_o) begin
                done_seen = 1;
                cfg_at_done = cur_config_o;
                break;
            end
            if (cur_config_o !== cfg_before) cfg_early = 1;
            if (tx_valid_o && prev_v && tx_data_o !== prev_d) stable_ok = 0;
            prev_v = tx_valid_o;
            prev_d = tx_data_o;
            tx_done_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) tx_done_i = 1'b1;
            end
            if (spurious && tx_valid_o) tx_done_i = 1'b1;
            start_i = second_start && (cyc == 20);
            req_config_i = (second_start && cyc == 20) ? 6'b000000 : cfg;
            tx_ready_i = 1'b1;
            if (tx_valid_o && cap_n == 3 && low_left > 0) begin
                tx_ready_i = 1'b0;
                low_left--;
            end
            if (tx_valid_o && tx_ready_i) begin
                if (cap_n < 16) cap[cap_n] = tx_data_o;
                cap_n++;
                pend = 10;
            end
            tick();
            cyc++;
        end
        start_i = 1'b0;
        tx_done_i = 1'b0;
        req_config_i = cfg;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        checks++; if (tx_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", tx_valid_o); else passes++;
        checks++; if (tx_data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", tx_data_o); else passes++;
        checks++; if ({busy_o, done_o, error_o} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy_o, done_o, error_o}); else passes++;
        checks++; if (cur_config_o !== 6'b110000) $display("FAIL reset_config: got %b want 110000", cur_config_o); else passes++;
        tick();
        checks++; if ({tx_valid_o, busy_o} !== 2'b00) $display("FAIL reset_idle: got %b want 00", {tx_valid_o, busy_o}); else passes++;
    endtask

    task automatic test_default();
        exp_b = '{8'h16, 8'h16, 8'h16, 8'h0D, 8'h02, 8'h03, 8'h00};
        run_seq(6'b110000, 0, 0, 0);
        checks++; if (cap_n !== 7) $display("FAIL default_count: got %0d want 7", cap_n); else passes++;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) $display("FAIL default_byte%0d: got %h want %h", i, cap[i], exp_b[i]); else passes++;
        end
        checks++; if (done_seen !== 1'b1) $display("FAIL default_done: got %b want 1", done_seen); else passes++;
        checks++; if (cfg_at_done !== 6'b110000) $display("FAIL default_config: got %b want 110000", cfg_at_done); else passes++;
        tick();
        checks++; if ({done_o, busy_o} !== 2'b00) $display("FAIL default_done_pulse: got %b want 00", {done_o, busy_o}); else passes++;
    endtask

    task automatic test_cfg_7o2();
        exp_b = '{8'h16, 8'h16, 8'h16, 8'h09, 8'h06, 8'h07, 8'h00};
        run_seq(6'b100101, 0, 0, 0);
        checks++; if (cap_n !== 7) $display("FAIL 7o2_count: got %0d want 7", cap_n); else passes++;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) $display("FAIL 7o2_byte%0d: got %h want %h", i, cap[i], exp_b[i]); else passes++;
        end
        checks++; if (cfg_early !== 1'b0) $display("FAIL 7o2_early_config: got %b want 0", cfg_early); else passes++;
        checks++; if (cfg_at_done !== 6'b100101) $display("FAIL 7o2_config: got %b want 100101", cfg_at_done); else passes++;
        tick();
    endtask

    task automatic test_reserved();
        bit saw_valid;
        req_config_i = 6'b110010;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (error_o !== 1'b1) $display("FAIL reserved1_error: got %b want 1", error_o); else passes++;
        checks++; if ({tx_valid_o, busy_o} !== 2'b00) $display("FAIL reserved1_idle: got %b want 00", {tx_valid_o, busy_o}); else passes++;
        tick();
        checks++; if (error_o !== 1'b0) $display("FAIL reserved1_pulse: got %b want 0", error_o); else passes++;
        req_config_i = 6'b000011;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (error_o !== 1'b1) $display("FAIL reserved2_error: got %b want 1", error_o); else passes++;
        saw_valid = 0;
        for (int i = 0; i < 15; i++) begin
            if (tx_valid_o) saw_valid = 1;
            tick();
        end
        checks++; if (saw_valid !== 1'b0) $display("FAIL reserved_no_tx: got %b want 0", saw_valid); else passes++;
        checks++; if (cur_config_o !== 6'b100101) $display("FAIL reserved_config: got %b want 100101", cur_config_o); else passes++;
    endtask

    task automatic test_spurious();
        tx_done_i = 1'b1;
        tick();
        tick();
        tick();
        tx_done_i = 1'b0;
        checks++; if ({tx_valid_o, busy_o} !== 2'b00) $display("FAIL spurious_idle: got %b want 00", {tx_valid_o, busy_o}); else passes++;
        exp_b = '{8'h16, 8'h16, 8'h16, 8'h0D, 8'h02, 8'h03, 8'h00};
        run_seq(6'b110000, 0, 0, 1);
        checks++; if (cap_n !== 7) $display("FAIL spurious_count: got %0d want 7", cap_n); else passes++;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) $display("FAIL spurious_byte%0d: got %h want %h", i, cap[i], exp_b[i]); else passes++;
        end
        checks++; if (cfg_at_done !== 6'b110000) $display("FAIL spurious_config: got %b want 110000", cfg_at_done); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        bit extra;
        exp_b = '{8'h16, 8'h16, 8'h16, 8'h09, 8'h06, 8'h07, 8'h00};
        run_seq(6'b100101, 5, 1, 0);
        checks++; if (cap_n !== 7) $display("FAIL backpressure_count: got %0d want 7", cap_n); else passes++;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) $display("FAIL backpressure_byte%0d: got %h want %h", i, cap[i], exp_b[i]); else passes++;
        end
        checks++; if (stable_ok !== 1'b1) $display("FAIL backpressure_stable: got %b want 1", stable_ok); else passes++;
        checks++; if (cfg_at_done !== 6'b100101) $display("FAIL backpressure_config: got %b want 100101", cfg_at_done); else passes++;
        tick();
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_valid_o || busy_o) extra = 1;
            tick();
        end
        checks++; if (extra !== 1'b0) $display("FAIL backpressure_no_extra: got %b want 0", extra); else passes++;
    endtask

    task automatic test_reset_mid();
        int pend;
        bit reached;
        pend = 0; reached = 0; cap_n = 0;
        req_config_i = 6'b001001;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cap_n == 2 && tx_valid_o) begin
                reached = 1;
                break;
            end
            tx_done_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) tx_done_i = 1'b1;
            end
            tx_ready_i = 1'b1;
            if (tx_valid_o) begin
                cap_n++;
                pend = 10;
            end
            tick();
        end
        tx_done_i = 1'b0;
        checks++; if (reached !== 1'b1) $display("FAIL midreset_reach: got %b want 1", reached); else passes++;
        checks++; if (tx_data_o !== 8'h16) $display("FAIL midreset_third_syn: got %h want 16", tx_data_o); else passes++;
        tx_ready_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++; if ({tx_valid_o, busy_o, done_o, error_o} !== 4'b0000) $display("FAIL midreset_flags: got %b want 0000", {tx_valid_o, busy_o, done_o, error_o}); else passes++;
        checks++; if (tx_data_o !== 8'h00) $display("FAIL midreset_data: got %h want 00", tx_data_o); else passes++;
        checks++; if (cur_config_o !== 6'b110000) $display("FAIL midreset_config: got %b want 110000", cur_config_o); else passes++;
        tick();
        exp_b = '{8'h16, 8'h16, 8'h16, 8'h01, 8'h0A, 8'h07, 8'h00};
        run_seq(6'b001001, 0, 0, 0);
        checks++; if (cap_n !== 7) $display("FAIL restart_count: got %0d want 7", cap_n); else passes++;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) $display("FAIL restart_byte%0d: got %h want %h", i, cap[i], exp_b[i]); else passes++;
        end
        checks++; if (cfg_at_done !== 6'b001001) $display("FAIL restart_config: got %b want 001001", cfg_at_done); else passes++;
        tick();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_i = 1'b0;
        start_i = 1'b0;
        req_config_i = 6'b110000;
        tx_ready_i = 1'b0;
        tx_done_i = 1'b0;
        test_reset();
        test_default();
        test_cfg_7o2();
        test_reserved();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_config_requester.md
Name: uart_config_requester

Overview:
- Initiator side of the UART run-time configuration protocol. The device-side receiver detects SYN characters and then decodes configuration packets; this block produces that sequence.
- On a start pulse it emits SYN_NUMBER SYN characters, then one configuration packet each for data width, parity mode and stop bits, then an END_CONFIGURATION packet.
- Bytes are handed one at a time to the local UART transmitter over a valid/ready handshake.
- Once the last byte has been fully shifted out, the new configuration is applied locally.

Parameters:
- SYN_COUNT, default SYN_NUMBER (3): number of leading SYN characters sent.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  single-cycle request to begin a configuration sequence.
- req_config_i  in  6  requested configuration, uart_config_s {data_width, parity_mode, stop_bits}.
- tx_valid_o  out  1  byte on tx_data_o is valid.
- tx_ready_i  in  1  transmitter accepts the byte this cycle.
- tx_data_o  out  8  byte to transmit.
- tx_done_i  in  1  single-cycle pulse: the accepted byte has been fully serialised, including stop bits.
- busy_o  out  1  sequence in progress.
- done_o  out  1  single-cycle pulse: sequence complete, new configuration applied.
- error_o  out  1  single-cycle pulse: requested configuration is illegal and was rejected.
- cur_config_o  out  6  configuration currently in force.

Behaviour:
- Reset values:
  - tx_valid_o=0, tx_data_o=0, busy_o=0, done_o=0, error_o=0.
  - cur_config_o=STD_CONFIGURATION, i.e. {DW_8BIT, EVEN, SB_1BIT} = 6'b110000.
  - FSM in IDLE, SYN counter 0, latched config = STD_CONFIGURATION.
- States: IDLE, SEND_SYN, SEND_DW, SEND_PM, SEND_SB, SEND_END. Each SEND state has two phases:
  - OFFER: tx_valid_o=1 until tx_valid_o && tx_ready_i.
  - WAIT: tx_valid_o=0 until tx_done_i.
- IDLE, start_i=1:
  - req_config_i is latched.
  - If stop_bits is RESERVED1 or RESERVED2: error_o pulses the next cycle, no byte is sent, state stays IDLE, cur_config_o is unchanged.
  - Otherwise: go to SEND_SYN; busy_o=1 and tx_valid_o=1 with tx_data_o=SYN (8'h16) from the next cycle.
- Parity DISABLED1 and DISABLED2 are legal and sent verbatim. All data widths are legal.
- Handshake rules:
  - tx_data_o is stable while tx_valid_o=1.
  - tx_valid_o is never withdrawn before acceptance.
  - After acceptance, tx_valid_o drops the next cycle.
  - tx_done_i seen in OFFER phase, or in IDLE, is ignored.
  - tx_done_i arriving in the same cycle as acceptance does not count for that byte.
- SEND_SYN: repeats SYN until SYN_COUNT bytes have completed; the counter increments on each tx_done_i; then go to SEND_DW.
- Packet bytes are {4'b0, option, id}, per assemble_packet:
  - SEND_DW: option=data_width, id=DATA_WIDTH_ID.
  - SEND_PM: option=parity_mode, id=PARITY_MODE_ID.
  - SEND_SB: option=stop_bits, id=STOP_BITS_ID.
  - SEND_END: 8'h00.
- Next-byte latency: the next byte is offered the cycle after tx_done_i.
- Completion: on tx_done_i in SEND_END WAIT, the next cycle has cur_config_o = latched config, done_o=1 for 1 cycle, busy_o=0, state IDLE.
- start_i while busy_o=1 is ignored and does not relatch the configuration.
- A new start_i in the same cycle done_o is high is accepted; the FSM is already in IDLE.
- Reset mid-sequence: everything returns to reset values, including cur_config_o. tx_valid_o drops in the cycle after rst_i is sampled.
- tx_ready_i is don't-care when tx_valid_o=0.

Decomposition:
- Add to UART_pkg:
  - requester_state_e enum (3 bits).
  - CFG_SEQ_LENGTH = SYN_NUMBER + 4.
  - function is_legal_config(uart_config_s) returning 0 for reserved stop bits.
- Reuse the existing uart_config_s, assemble_packet, the ID constants and SYN.
- No sub-module: a single FSM plus a 2-bit SYN counter and a phase bit.

Test Plan:
- Default request {DW_8BIT, EVEN, SB_1BIT}, tx_ready_i=1, tx_done_i 10 cycles after each accept:
  - Expect bytes 16,16,16,0D,02,03,00.
  - Expect done_o pulse; cur_config_o=6'b110000.
- Request {DW_7BIT, ODD, SB_2BIT}:
  - Expect bytes 16,16,16,09,06,07,00.
  - Expect cur_config_o=6'b100101 only after the final tx_done_i.
- Request stop_bits=RESERVED1:
  - Expect error_o pulse next cycle, tx_valid_o never asserted, cur_config_o unchanged.
- tx_ready_i held low 5 cycles on the first packet byte, plus a second start_i issued mid-sequence:
  - tx_data_o stays 09 and stable while tx_valid_o=1.
  - The second start is ignored; exactly 7 bytes are sent.
- Spurious tx_done_i during the OFFER phase and in IDLE:
  - No byte is skipped; SYN count stays 3.
- rst_i asserted after the 2nd SYN is accepted:
  - All outputs return to reset values within 1 cycle.
  - A fresh start_i re-sends 3 SYN.
